// File: rtl/handshake_tx_arbiter_pkg.sv
// Shared types for the handshake TX arbiter and its round-robin helper.
// The one-hot state encoding is fixed so illegal patterns are easy to recognise.
package handshake_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_WAIT_LO = 3'b010,
        ST_WAIT_HI = 3'b100
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational masked round-robin arbiter: searches upward from ptr+1 with wrap-around.
// Kept free of any transfer protocol so other shared-resource blocks can reuse it.
module rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [N-1:0]  w_mask;
    logic [N-1:0]  w_masked;
    logic [IW-1:0] w_idx_hi;
    logic [IW-1:0] w_idx_lo;
    logic          w_hit_hi;

    // The masked half holds requesters above ptr; the unmasked search covers the wrap.
    always_comb begin
        w_mask   = '0;
        w_idx_hi = '0;
        w_idx_lo = '0;
        w_hit_hi = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i > int'(ptr));
        end
        w_masked = req & w_mask;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_hit_hi = 1'b1;
                w_idx_hi = IW'(i);
            end
            if (req[i]) begin
                w_idx_lo = IW'(i);
            end
        end
    end

    assign any        = |req;
    assign gnt_idx    = w_hit_hi ? w_idx_hi : w_idx_lo;
    assign gnt_onehot = any ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/handshake_tx_arbiter.sv
// Shares one full-handshake CDC transmitter among N TX-domain requesters by round-robin,
// captures the winner's word, and tracks the 4-phase transfer through the transmitter idle flag.
module handshake_tx_arbiter
    import handshake_tx_arbiter_pkg::*;
#(
    parameter int  N  = 4,
    parameter int  DW = 32,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    input  logic [N*DW-1:0] req_data_i,
    output logic [N-1:0]    gnt_o,
    output logic [N-1:0]    done_o,
    output logic            busy_o,
    output logic [IW-1:0]   src_o,
    input  logic            tx_idle_i,
    output logic            tx_req_o,
    output logic [DW-1:0]   tx_data_o
);

    state_t        r_state;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_src;
    logic [DW-1:0] r_data;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  r_done;
    logic          r_tx_req;
    logic          r_busy;

    logic [N-1:0]  w_gnt_onehot;
    logic [IW-1:0] w_gnt_idx;
    logic          w_any;
    logic [DW-1:0] w_sel_data;
    logic [N-1:0]  w_src_onehot;

    rr_arbiter #(
        .N (N)
    ) u_rr (
        .req        (req_i),
        .ptr        (r_ptr),
        .gnt_onehot (w_gnt_onehot),
        .gnt_idx    (w_gnt_idx),
        .any        (w_any)
    );

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt_idx == IW'(k)) begin
                w_sel_data = req_data_i[k*DW +: DW];
            end
        end
    end

    assign w_src_onehot = N'(1) << r_src;

    // Pointer starts at N-1 so requester 0 wins the first round after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_ptr    <= IW'(N - 1);
            r_src    <= '0;
            r_data   <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_tx_req <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_gnt    <= '0;
            r_done   <= '0;
            r_tx_req <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any && tx_idle_i) begin
                        r_gnt    <= w_gnt_onehot;
                        r_tx_req <= 1'b1;
                        r_data   <= w_sel_data;
                        r_src    <= w_gnt_idx;
                        r_ptr    <= w_gnt_idx;
                        r_busy   <= 1'b1;
                        r_state  <= ST_WAIT_LO;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tx_idle_i) begin
                        r_state <= ST_WAIT_HI;
                    end
                end
                ST_WAIT_HI: begin
                    // Idle returning high means the ack has dropped: the 4-phase cycle is closed.
                    if (tx_idle_i) begin
                        r_done  <= w_src_onehot;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_src   <= '0;
                    r_data  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o     = r_gnt;
    assign done_o    = r_done;
    assign busy_o    = r_busy;
    assign src_o     = r_src;
    assign tx_req_o  = r_tx_req;
    assign tx_data_o = r_data;

endmodule
